lcd_ctrl_param: RTL and testbench

Parametrised successor to the 8x8 LCD image controller. Loads an IMG_W x IMG_H image of DW-bit pixels from IROM into internal storage, then executes single-nibble commands on a 2x2 window around a movable operation point, and writes the full image to IRAM on command. Generalises image width, height and pixel width. Adds repeatable write (multiple dumps per run), a recenter command and an invert command. Sits between the command source and the IROM/IRAM macros in the LCD test system.

---
 rtl/lcd_ctrl_param_if.sv | 27 ++
 rtl/lcd_ctrl_param.sv | 181 ++++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_param_if.sv
// Bus bundle between the LCD controller, its command source and the IROM/IRAM macros.
// The master side is the controller; the slave side is the environment around it.
interface lcd_ctrl_param_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H image from IROM, edits a
// 2x2 window around a movable point on command, and dumps the image to IRAM on request.
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input logic              clk,
  input logic              reset,
  lcd_ctrl_param_if.master lcd
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;
  typedef enum logic [3:0] {
    C_WRITE, C_UP, C_DOWN, C_LEFT, C_RIGHT, C_MAX, C_MIN, C_AVG,
    C_ROT_CCW, C_ROT_CW, C_MIR_X, C_MIR_Y, C_CENTER, C_INVERT, C_RSV_E, C_RSV_F
  } cmd_t;

  state_t        state, state_nxt;
  cmd_t          cmd_q;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [DW-1:0] img [N];

  // Power-of-two dimensions make the raster address a plain {y, x} concatenation.
  logic [XW-1:0] px_m1;
  logic [YW-1:0] py_m1;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br, wr_a_nxt;
  assign px_m1    = px - 1'b1;
  assign py_m1    = py - 1'b1;
  assign a_tl     = {py_m1, px_m1};
  assign a_tr     = {py_m1, px};
  assign a_bl     = {py, px_m1};
  assign a_br     = {py, px};
  assign wr_a_nxt = lcd.IRAM_A + 1'b1;

  logic [DW-1:0] p_tl, p_tr, p_bl, p_br, mx, mn, avg;
  logic [DW+1:0] sum;
  assign p_tl = img[a_tl];
  assign p_tr = img[a_tr];
  assign p_bl = img[a_bl];
  assign p_br = img[a_br];
  assign sum  = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
  assign avg  = DW'(sum >> 2);

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign mx = max2(max2(p_tl, p_tr), max2(p_bl, p_br));
  assign mn = min2(min2(p_tl, p_tr), min2(p_bl, p_br));

  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic          win_we;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    n_tl   = p_tl;
    n_tr   = p_tr;
    n_bl   = p_bl;
    n_br   = p_br;
    win_we = (state == S_EXEC);
    case (cmd_q)
      C_MAX:     begin n_tl = mx;  n_tr = mx;  n_bl = mx;  n_br = mx;  end
      C_MIN:     begin n_tl = mn;  n_tr = mn;  n_bl = mn;  n_br = mn;  end
      C_AVG:     begin n_tl = avg; n_tr = avg; n_bl = avg; n_br = avg; end
      C_ROT_CCW: begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
      C_ROT_CW:  begin n_tl = p_bl; n_bl = p_br; n_br = p_tr; n_tr = p_tl; end
      C_MIR_X:   begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
      C_MIR_Y:   begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
      C_INVERT:  begin n_tl = ~p_tl; n_tr = ~p_tr; n_bl = ~p_bl; n_br = ~p_br; end
      default:   win_we = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (lcd.IROM_rd && lcd.IROM_A == LAST) state_nxt = S_IDLE;
      S_IDLE:  if (lcd.cmd_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (cmd_q == C_WRITE) ? S_WRITE : S_IDLE;
      S_WRITE: if (lcd.IRAM_A == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd.IROM_rd    <= 1'b0;
      lcd.IROM_A     <= '0;
      lcd.IRAM_valid <= 1'b0;
      lcd.IRAM_A     <= '0;
      lcd.IRAM_D     <= '0;
      lcd.busy       <= 1'b1;
      lcd.done       <= 1'b0;
      px             <= XW'(IMG_W / 2);
      py             <= YW'(IMG_H / 2);
      cmd_q          <= C_WRITE;
    end else begin
      case (state)
        S_LOAD: begin
          if (!lcd.IROM_rd) begin
            lcd.IROM_rd <= 1'b1;
          end else begin
            lcd.IROM_A <= lcd.IROM_A + 1'b1;
            if (lcd.IROM_A == LAST) begin
              lcd.IROM_rd <= 1'b0;
              lcd.busy    <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (lcd.cmd_valid) begin
            cmd_q    <= cmd_t'(lcd.cmd);
            lcd.busy <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cmd_q)
            C_UP:     if (py != YW'(1))         py <= py - 1'b1;
            C_DOWN:   if (py != YW'(IMG_H - 1)) py <= py + 1'b1;
            C_LEFT:   if (px != XW'(1))         px <= px - 1'b1;
            C_RIGHT:  if (px != XW'(IMG_W - 1)) px <= px + 1'b1;
            C_CENTER: begin
              px <= XW'(IMG_W / 2);
              py <= YW'(IMG_H / 2);
            end
            C_WRITE: begin
              lcd.IRAM_valid <= 1'b1;
              lcd.IRAM_A     <= '0;
              lcd.IRAM_D     <= img[0];
            end
            default: ;
          endcase
          if (cmd_q != C_WRITE) lcd.busy <= 1'b0;
        end
        S_WRITE: begin
          if (lcd.IRAM_A == LAST) begin
            lcd.IRAM_valid <= 1'b0;
            lcd.done       <= 1'b1;
          end else begin
            lcd.IRAM_A <= wr_a_nxt;
            lcd.IRAM_D <= img[wr_a_nxt];
          end
        end
        S_DONE: begin
          lcd.done <= 1'b0;
          lcd.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: image storage is deliberately left out of reset; it is only written while LOAD or EXEC is active.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && lcd.IROM_rd) img[lcd.IROM_A] <= lcd.IROM_Q;
    if (win_we) begin
      img[a_tl] <= n_tl;
      img[a_tr] <= n_tr;
      img[a_bl] <= n_bl;
      img[a_br] <= n_br;
    end
  end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: an 8x8x8 instance and a 16x4x10 instance,
// directed window cases plus random command streams checked against an image model.
module tb_lcd_ctrl_param;
  localparam int N = 64;

  logic       clk = 1'b0;
  logic       reset, sel;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       rst0, rst1;

  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.AW(6), .DW(8))  b0 ();
  lcd_ctrl_param_if #(.AW(6), .DW(10)) b1 ();

  assign rst0         = reset | sel;
  assign rst1         = reset | ~sel;
  assign b0.cmd       = cmd;
  assign b1.cmd       = cmd;
  assign b0.cmd_valid = cmd_valid & ~sel;
  assign b1.cmd_valid = cmd_valid & sel;

  lcd_ctrl_param #(.IMG_W(8),  .IMG_H(8), .DW(8))  dut0 (.clk(clk), .reset(rst0), .lcd(b0));
  lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(10)) dut1 (.clk(clk), .reset(rst1), .lcd(b1));

  logic       busy_o, done_o, rd_o, valid_o;
  logic [5:0] roma_o, rama_o;
  logic [9:0] ramd_o;
  assign busy_o  = sel ? b1.busy       : b0.busy;
  assign done_o  = sel ? b1.done       : b0.done;
  assign rd_o    = sel ? b1.IROM_rd    : b0.IROM_rd;
  assign valid_o = sel ? b1.IRAM_valid : b0.IRAM_valid;
  assign roma_o  = sel ? b1.IROM_A     : b0.IROM_A;
  assign rama_o  = sel ? b1.IRAM_A     : b0.IRAM_A;
  assign ramd_o  = sel ? b1.IRAM_D     : {2'b00, b0.IRAM_D};

  int rom [N];
  int ram [N];
  int m_img [N];
  int m_px, m_py, m_w, m_h, m_max;
  int checks = 0, errors = 0;
  int done_cnt, wr_cnt;

  // IROM and IRAM macro models act on the falling edge.
  always @(negedge clk) begin
    if (b0.IROM_rd) b0.IROM_Q = 8'(rom[b0.IROM_A]);
    if (b1.IROM_rd) b1.IROM_Q = 10'(rom[b1.IROM_A]);
    if (valid_o) begin
      ram[rama_o] = int'(ramd_o);
      wr_cnt++;
    end
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: applies one command to the image array and point.
  function automatic void m_apply(input int c);
    int tl, tr, bl, br, a, b, cc, d, v;
    tl = (m_py - 1) * m_w + m_px - 1;
    tr = tl + 1;
    bl = tl + m_w;
    br = bl + 1;
    a = m_img[tl]; b = m_img[tr]; cc = m_img[bl]; d = m_img[br];
    case (c)
      1: if (m_py > 1) m_py--;
      2: if (m_py < m_h - 1) m_py++;
      3: if (m_px > 1) m_px--;
      4: if (m_px < m_w - 1) m_px++;
      5, 6, 7: begin
        if (c == 5)      v = (a > b ? a : b) > (cc > d ? cc : d) ? (a > b ? a : b) : (cc > d ? cc : d);
        else if (c == 6) v = (a < b ? a : b) < (cc < d ? cc : d) ? (a < b ? a : b) : (cc < d ? cc : d);
        else             v = (a + b + cc + d) / 4;
        m_img[tl] = v; m_img[tr] = v; m_img[bl] = v; m_img[br] = v;
      end
      8:  begin m_img[tl] = b;  m_img[tr] = d;  m_img[br] = cc; m_img[bl] = a;  end
      9:  begin m_img[tl] = cc; m_img[bl] = d;  m_img[br] = b;  m_img[tr] = a;  end
      10: begin m_img[tl] = cc; m_img[bl] = a;  m_img[tr] = d;  m_img[br] = b;  end
      11: begin m_img[tl] = b;  m_img[tr] = a;  m_img[bl] = d;  m_img[br] = cc; end
      12: begin m_px = m_w / 2; m_py = m_h / 2; end
      13: begin
        m_img[tl] = m_max - a; m_img[tr] = m_max - b;
        m_img[bl] = m_max - cc; m_img[br] = m_max - d;
      end
      default: ;
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check({tag, "_timeout"}, 32'(busy_o), 0);
  endtask

  task automatic load(input int w, input int h, input int dw, input logic s);
    int n;
    reset = 1'b1; cmd_valid = 1'b0; sel = s;
    m_w = w; m_h = h; m_max = (1 << dw) - 1; m_px = w / 2; m_py = h / 2;
    for (int i = 0; i < N; i++) m_img[i] = rom[i];
    @(negedge clk);
    check("rst_busy",  32'(busy_o),  1);
    check("rst_done",  32'(done_o),  0);
    check("rst_rd",    32'(rd_o),    0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_roma",  32'(roma_o),  0);
    check("rst_rama",  32'(rama_o),  0);
    check("rst_ramd",  32'(ramd_o),  0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check("load_rd",   32'(rd_o),   1);
        check("load_roma", 32'(roma_o), 0);
      end
    end while (busy_o && n < 500);
    check("load_cycles", n, N + 1);
  endtask

  task automatic send(input int c);
    int n;
    wait_idle("pre_idle");
    @(negedge clk);
    cmd = 4'(c); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept", 32'(busy_o), 1);
    n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (c == 0) check("write_busy", n, m_w * m_h + 2);
    else begin
      check($sformatf("exec_busy_c%0d", c), n, 1);
      m_apply(c);
    end
  endtask

  task automatic do_write(input string tag);
    for (int i = 0; i < N; i++) ram[i] = -1;
    done_cnt = 0; wr_cnt = 0;
    send(0);
    @(negedge clk); @(negedge clk);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_wrcnt"}, wr_cnt, N);
    check({tag, "_busy"}, 32'(busy_o), 0);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), ram[i], m_img[i]);
  endtask

  // Directed window cases: command and expected TL, TR, BL, BR.
  int win_tab [7][5] = '{
    '{7, 25, 25, 25, 25}, '{5, 41, 41, 41, 41}, '{6, 10, 10, 10, 10},
    '{8, 20, 41, 10, 30}, '{9, 30, 10, 41, 20},
    '{10, 30, 41, 10, 20}, '{11, 20, 10, 41, 30}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, diffs;
    logic prev;
    int snap [N];
    reset = 1'b1; sel = 1'b0; cmd = '0; cmd_valid = 1'b0;

    // Ramp image straight through.
    for (int i = 0; i < N; i++) rom[i] = i;
    load(8, 8, 8, 1'b0);
    do_write("ramp");
    check("ramp_last", ram[63], 63);

    // Window arithmetic and permutations around point (4,4).
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < N; i++) rom[i] = int'($urandom_range(0, 255));
      rom[27] = 10; rom[28] = 20; rom[35] = 30; rom[36] = 41;
      load(8, 8, 8, 1'b0);
      send(win_tab[t][0]);
      do_write($sformatf("win_c%0d", win_tab[t][0]));
      check("win_tl", ram[27], win_tab[t][1]);
      check("win_tr", ram[28], win_tab[t][2]);
      check("win_bl", ram[35], win_tab[t][3]);
      check("win_br", ram[36], win_tab[t][4]);
    end

    // Right-edge clamp, invert, recenter, held strobe, back-to-back writes.
    for (int i = 0; i < N; i++) rom[i] = 0;
    load(8, 8, 8, 1'b0);
    repeat (7) send(4);
    send(13);
    do_write("inv");
    check("inv_30", ram[30], 255);
    check("inv_39", ram[39], 255);
    check("inv_29", ram[29], 0);
    send(12);
    send(13);
    wait_idle("hold_idle");
    @(negedge clk);
    cmd = 4'd3; cmd_valid = 1'b1;
    acc = 0; prev = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy_o && !prev) acc++;
      prev = busy_o;
    end
    cmd_valid = 1'b0;
    check("hold_accepts", acc, 5);
    for (int k = 0; k < acc; k++) m_apply(3);
    send(13);
    do_write("wr1");
    for (int i = 0; i < N; i++) snap[i] = ram[i];
    do_write("wr2");
    diffs = 0;
    for (int i = 0; i < N; i++) if (snap[i] != ram[i]) diffs++;
    check("wr_identical", diffs, 0);

    // Random command stream.
    for (int i = 0; i < N; i++) rom[i] = int'($urandom_range(0, 255));
    load(8, 8, 8, 1'b0);
    for (int k = 1; k <= 150; k++) begin
      send(int'($urandom_range(1, 15)));
      if (k % 30 == 0) do_write($sformatf("rnd%0d", k));
    end

    // 16x4 image with 10-bit pixels.
    for (int i = 0; i < N; i++) rom[i] = int'($urandom_range(0, 1023));
    load(16, 4, 10, 1'b1);
    repeat (3) send(2);
    send(13);
    do_write("p16");
    for (int k = 0; k < 40; k++) send(int'($urandom_range(1, 15)));
    do_write("p16r");

    // Reset in the middle of a write.
    wait_idle("mid_idle");
    @(negedge clk);
    cmd = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(valid_o && rama_o == 6'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("mid_timeout", 1, 0);
    reset = 1'b1;
    #1;
    check("mid_busy",  32'(busy_o),  1);
    check("mid_valid", 32'(valid_o), 0);
    check("mid_rd",    32'(rd_o),    0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_reload_rd",   32'(rd_o),   1);
    check("mid_reload_roma", 32'(roma_o), 0);
    n = 1;
    while (busy_o && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reload_cycles", n, N + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
